// File: rtl/vc_sched4.sv
// vc_sched4 -- per-output-port oldest-first scheduler for 4 virtual channels.
//
// Each cycle the oldest eligible VC (smallest timestamp) is chosen through a
// tree of three 2-input min-compares. A VC is eligible when it requests and
// holds a downstream credit. The winner is registered and held as a grant
// until the switch accepts it. Per-VC downstream credit counters live here.
//
// Ports:
//   i_clk              clock, rising edge
//   i_reset            synchronous active-high reset
//   i_req_valid[3:0]   VC i has a head flit waiting
//   i_time_in_0..3     head-flit timestamps (smaller = older)
//   i_credit_ret_valid downstream returned one credit
//   i_credit_ret_vc    VC of the returned credit
//   i_grant_ready      switch accepts the current grant this cycle
//   o_grant_valid      a grant is presented
//   o_grant_vc         granted VC index
//   o_grant_time       timestamp of granted VC, captured at arbitration
//   o_pop[3:0]         one-hot dequeue pulse on handshake
//   o_credit_err       sticky: credit returned to a full counter
module vc_sched4 #(
   parameter int TIME_WIDTH   = 8,
   parameter int VC_DEPTH     = 4,
   parameter int CREDIT_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [3:0]            i_req_valid,
   input  logic [TIME_WIDTH-1:0] i_time_in_0,
   input  logic [TIME_WIDTH-1:0] i_time_in_1,
   input  logic [TIME_WIDTH-1:0] i_time_in_2,
   input  logic [TIME_WIDTH-1:0] i_time_in_3,
   input  logic                  i_credit_ret_valid,
   input  logic [1:0]            i_credit_ret_vc,
   input  logic                  i_grant_ready,
   output logic                  o_grant_valid,
   output logic [1:0]            o_grant_vc,
   output logic [TIME_WIDTH-1:0] o_grant_time,
   output logic [3:0]            o_pop,
   output logic                  o_credit_err
);

   localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(VC_DEPTH);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t                        r_state, w_state_nxt;
   logic [1:0]                    r_grant_vc, w_vc_nxt;
   logic [TIME_WIDTH-1:0]         r_grant_time, w_time_nxt;
   logic [3:0][CREDIT_WIDTH-1:0]  r_credit;
   logic                          r_credit_err;

   logic [3:0][TIME_WIDTH-1:0]    w_time;
   logic                          w_hs;
   logic [3:0]                    w_hs_vec, w_ret_vec, w_mask, w_elig;
   logic                          w_lo_v, w_hi_v, w_lo_idx, w_hi_idx, w_pick_hi, w_any;
   logic [TIME_WIDTH-1:0]         w_lo_t, w_hi_t, w_win_t;
   logic [1:0]                    w_win_vc;
   logic                          w_err_set;

   assign w_time = {i_time_in_3, i_time_in_2, i_time_in_1, i_time_in_0};

   // Handshake is suppressed on the reset cycle so no pop escapes.
   assign w_hs      = (r_state == GRANT) & i_grant_ready & ~i_reset;
   assign w_hs_vec  = w_hs ? (4'b0001 << r_grant_vc) : 4'b0000;
   assign w_ret_vec = i_credit_ret_valid ? (4'b0001 << i_credit_ret_vc) : 4'b0000;
   // The VC being popped this cycle is masked so a requester that keeps
   // req_valid high for one more cycle is not granted twice.
   assign w_mask    = w_hs_vec;

   always_comb begin
      for (int i = 0; i < 4; i++)
         w_elig[i] = i_req_valid[i] & (r_credit[i] != '0) & ~w_mask[i];
   end

   // Min-compare tree; strict '<' gives ties to the lower index.
   always_comb begin
      w_lo_v    = w_elig[0] | w_elig[1];
      w_lo_idx  = w_elig[1] & (~w_elig[0] | (w_time[1] < w_time[0]));
      w_lo_t    = w_lo_idx ? w_time[1] : w_time[0];
      w_hi_v    = w_elig[2] | w_elig[3];
      w_hi_idx  = w_elig[3] & (~w_elig[2] | (w_time[3] < w_time[2]));
      w_hi_t    = w_hi_idx ? w_time[3] : w_time[2];
      w_pick_hi = w_hi_v & (~w_lo_v | (w_hi_t < w_lo_t));
      w_any     = w_lo_v | w_hi_v;
      w_win_vc  = w_pick_hi ? {1'b1, w_hi_idx} : {1'b0, w_lo_idx};
      w_win_t   = w_pick_hi ? w_hi_t : w_lo_t;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vc_nxt    = r_grant_vc;
      w_time_nxt  = r_grant_time;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_vc_nxt    = w_win_vc;
               w_time_nxt  = w_win_t;
            end
         end
         GRANT: begin
            if (w_hs) begin
               if (w_any) begin
                  w_vc_nxt   = w_win_vc;
                  w_time_nxt = w_win_t;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (!i_req_valid[r_grant_vc]) begin
               // Requester withdrew while the grant was stalled.
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_grant_vc   <= '0;
         r_grant_time <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_vc   <= w_vc_nxt;
         r_grant_time <= w_time_nxt;
      end
   end

   // A lone return into a full counter is dropped and flagged; a return
   // paired with a handshake decrement on the same VC nets to zero.
   always_comb begin
      w_err_set = 1'b0;
      for (int i = 0; i < 4; i++)
         if (w_ret_vec[i] & ~w_hs_vec[i] & (r_credit[i] == DEPTH_C))
            w_err_set = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 4; i++) r_credit[i] <= DEPTH_C;
         r_credit_err <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_hs_vec[i] & ~w_ret_vec[i])
               r_credit[i] <= r_credit[i] - 1'b1;
            else if (w_ret_vec[i] & ~w_hs_vec[i] & (r_credit[i] != DEPTH_C))
               r_credit[i] <= r_credit[i] + 1'b1;
         end
         if (w_err_set) r_credit_err <= 1'b1;
      end
   end

   assign o_grant_valid = (r_state == GRANT);
   assign o_grant_vc    = r_grant_vc;
   assign o_grant_time  = r_grant_time;
   assign o_pop         = w_hs_vec;
   assign o_credit_err  = r_credit_err;

endmodule

// File: tb/tb_vc_sched4.sv
// Directed bench for vc_sched4. Expected grants are queued as stimulus is
// driven and popped by a monitor whenever the DUT issues a pop.
module tb_vc_sched4;

   logic       clk, rst;
   logic [3:0] rv;
   logic [7:0] t0, t1, t2, t3;
   logic       crv, rdy;
   logic [1:0] crvc;
   logic       gv, err;
   logic [1:0] gvc;
   logic [7:0] gtime;
   logic [3:0] pop;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] vc;
      logic [7:0] t;
   } exp_t;
   exp_t sb[$];

   vc_sched4 #(.TIME_WIDTH(8), .VC_DEPTH(4), .CREDIT_WIDTH(3)) dut (
      .i_clk(clk), .i_reset(rst), .i_req_valid(rv),
      .i_time_in_0(t0), .i_time_in_1(t1), .i_time_in_2(t2), .i_time_in_3(t3),
      .i_credit_ret_valid(crv), .i_credit_ret_vc(crvc), .i_grant_ready(rdy),
      .o_grant_valid(gv), .o_grant_vc(gvc), .o_grant_time(gtime),
      .o_pop(pop), .o_credit_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [1:0] vc, input logic [7:0] t);
      exp_t e;
      e.vc = vc; e.t = t;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every pop must match the next queued grant.
   always @(negedge clk) begin
      if (!rst && pop !== 4'b0000) begin
         if (sb.size() == 0) chk("pop_unexpected", 32'(pop), 32'h0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pop",  32'(pop),   32'(4'b0001 << e.vc));
            chk("sb_time", 32'(gtime), 32'(e.t));
         end
      end
   end

   initial begin
      rst = 1'b1; rv = '0; t0 = '0; t1 = '0; t2 = '0; t3 = '0;
      crv = 1'b0; crvc = '0; rdy = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      chk("rst_gv",  32'(gv),  32'h0);
      chk("rst_pop", 32'(pop), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_vc",  32'(gvc), 32'h0);
      chk("rst_time",32'(gtime), 32'h0);
      cyc(); rst = 1'b0;

      // Oldest wins
      cyc(); rv = 4'b1111; t0 = 40; t1 = 10; t2 = 30; t3 = 20;
      @(negedge clk); chk("old_gv0", 32'(gv), 32'h0);
      cyc();
      @(negedge clk);
      chk("old_gv", 32'(gv), 32'h1);
      chk("old_vc", 32'(gvc), 32'h1);
      chk("old_t",  32'(gtime), 32'd10);
      cyc(); rdy = 1'b1; rv = 4'b0010; push(2'd1, 8'd10);
      @(negedge clk); chk("old_pop", 32'(pop), 32'b0010);
      cyc(); rdy = 1'b0; rv = 4'b0000;
      @(negedge clk);
      chk("old_idle", 32'(gv), 32'h0);
      chk("old_cr1",  32'(dut.r_credit[1]), 32'd3);

      // Tie and hold
      cyc(); rv = 4'b1111; t0 = 5; t1 = 5; t2 = 5; t3 = 5;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (k == 1) t2 = 1;
         @(negedge clk);
         chk("hold_gv", 32'(gv), 32'h1);
         chk("hold_vc", 32'(gvc), 32'h0);
         chk("hold_t",  32'(gtime), 32'd5);
         chk("hold_pop",32'(pop), 32'h0);
      end
      cyc(); rdy = 1'b1; push(2'd0, 8'd5);
      @(negedge clk); chk("tie_pop", 32'(pop), 32'b0001);
      cyc(); rdy = 1'b0;
      @(negedge clk);
      chk("tie_next_vc", 32'(gvc), 32'h2);
      chk("tie_next_t",  32'(gtime), 32'd1);
      chk("tie_next_gv", 32'(gv), 32'h1);
      cyc(); rdy = 1'b1; rv = 4'b0100; push(2'd2, 8'd1);
      cyc(); rdy = 1'b0; rv = 4'b0000;

      // Back-to-back and credit drain on VC3
      cyc(); rv = 4'b1000; t3 = 7; rdy = 1'b1;
      for (int k = 0; k < 4; k++) push(2'd3, 8'd7);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("drain_gv",  32'(gv),  (k < 8 && k % 2 == 1) ? 32'h1 : 32'h0);
         chk("drain_pop", 32'(pop), (k < 8 && k % 2 == 1) ? 32'b1000 : 32'h0);
         cyc();
      end
      chk("drain_cr3", 32'(dut.r_credit[3]), 32'h0);
      crv = 1'b1; crvc = 2'd3; push(2'd3, 8'd7);
      @(negedge clk); chk("ret_gv_r0", 32'(gv), 32'h0);
      cyc(); crv = 1'b0;
      @(negedge clk); chk("ret_gv_r1", 32'(gv), 32'h0);
      cyc();
      @(negedge clk);
      chk("ret_gv_r2",  32'(gv), 32'h1);
      chk("ret_pop_r2", 32'(pop), 32'b1000);
      cyc(); rv = 4'b0000; rdy = 1'b0;

      // Refill all counters to VC_DEPTH
      for (int k = 0; k < 7; k++) begin
         crv = 1'b1; crvc = (k < 3) ? 2'(k) : 2'd3;
         cyc();
      end
      crv = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk("refill_cr", 32'(dut.r_credit[i]), 32'd4);
      chk("refill_err", 32'(err), 32'h0);

      // Simultaneous handshake + return on VC1 at full credit
      cyc(); rv = 4'b0010; t1 = 9;
      cyc(); rdy = 1'b1; crv = 1'b1; crvc = 2'd1; push(2'd1, 8'd9);
      cyc(); rdy = 1'b0; crv = 1'b0; rv = 4'b0000;
      @(negedge clk);
      chk("simul_cr1", 32'(dut.r_credit[1]), 32'd4);
      chk("simul_err", 32'(err), 32'h0);
      cyc(); crv = 1'b1; crvc = 2'd1;
      cyc(); crv = 1'b0;
      @(negedge clk);
      chk("lone_err", 32'(err), 32'h1);
      chk("lone_cr1", 32'(dut.r_credit[1]), 32'd4);
      cyc(); cyc();
      @(negedge clk); chk("sticky_err", 32'(err), 32'h1);

      // Withdrawal of a stalled grant
      cyc(); rv = 4'b0100; t2 = 3;
      cyc();
      @(negedge clk);
      chk("wd_gv", 32'(gv), 32'h1);
      chk("wd_vc", 32'(gvc), 32'h2);
      cyc(); rv = 4'b0000;
      @(negedge clk); chk("wd_pop", 32'(pop), 32'h0);
      cyc();
      @(negedge clk);
      chk("wd_gv_after", 32'(gv), 32'h0);
      chk("wd_cr2", 32'(dut.r_credit[2]), 32'd4);

      // Reset mid-grant with credits partly consumed
      cyc(); rv = 4'b0001; t0 = 2; rdy = 1'b1;
      push(2'd0, 8'd2); push(2'd0, 8'd2);
      for (int k = 0; k < 4; k++) cyc();
      rdy = 1'b0;
      cyc();
      @(negedge clk);
      chk("mid_gv",  32'(gv), 32'h1);
      chk("mid_cr0", 32'(dut.r_credit[0]), 32'd2);
      cyc(); rst = 1'b1; rdy = 1'b1;
      @(negedge clk); chk("mid_rst_pop", 32'(pop), 32'h0);
      cyc(); rst = 1'b0; rdy = 1'b0; rv = 4'b0000;
      @(negedge clk);
      chk("post_rst_gv",  32'(gv),  32'h0);
      chk("post_rst_pop", 32'(pop), 32'h0);
      chk("post_rst_err", 32'(err), 32'h0);
      for (int i = 0; i < 4; i++) chk("post_rst_cr", 32'(dut.r_credit[i]), 32'd4);

      cyc();
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vc_sched4.md
Name: vc_sched4

Overview:
- Per-output-port sequential scheduler for 4 virtual channels (VCs).
- Each cycle it selects the oldest eligible VC, meaning the smallest timestamp. The selection tree is three 2-input min-compares.
- A VC is eligible when it is requesting and holds at least one downstream credit. The winner is registered and held as a grant to the switch until the switch accepts it.
- Owns the per-VC downstream credit counters. Sits between the input VC buffers and the crossbar/switch allocator.

Parameters:
- TIME_WIDTH, 8: width of each VC timestamp.
- VC_DEPTH, 4: downstream buffer depth per VC; also the credit counter reset value.
- CREDIT_WIDTH, 3: credit counter width; must satisfy 2^CREDIT_WIDTH > VC_DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  4  bit i set means VC i has a head flit waiting.
- time_in_0..time_in_3  input  TIME_WIDTH each  head-flit timestamp of VC 0..3; smaller means older.
- credit_ret_valid  input  1  downstream returned one credit.
- credit_ret_vc  input  2  VC index of the returned credit.
- grant_ready  input  1  switch accepts the current grant this cycle.
- grant_valid  output  1  a grant is presented.
- grant_vc  output  2  granted VC index.
- grant_time  output  TIME_WIDTH  timestamp of the granted VC, captured at arbitration.
- pop  output  4  one-hot, 1-cycle pulse; dequeue head flit of VC i.
- credit_err  output  1  sticky; set when a credit is returned to a full counter.

Behaviour:
- Reset: synchronous and active-high. Takes effect on the next rising edge regardless of state, including mid-grant. Reset values:
  - state=IDLE
  - grant_valid=0, grant_vc=0, grant_time=0
  - pop=0, credit_err=0
  - all credit[i]=VC_DEPTH
  - No pop is issued on the reset cycle.
- Eligibility: elig[i] = req_valid[i] & (credit[i] != 0) & ~mask[i].
  - mask[i] is 1 only for the VC being handshaken in the current cycle.
  - mask is 0 in all other cycles.
- Selection: minimum timestamp among eligible VCs.
  - Plain unsigned compare; no wrap-around handling.
  - Ties go to the lower index at every tree node.
  - A disabled leg never wins.
  - No eligible VC means no winner.
- States:
  - IDLE: if any elig, register winner index and its time_in into grant_vc/grant_time, set grant_valid=1, go to GRANT. Otherwise stay in IDLE with grant_valid=0. Latency is 1 cycle from req_valid to grant_valid.
  - GRANT, grant_ready=1 (handshake):
    - pop[grant_vc]=1 in the same cycle (combinational from the handshake).
    - credit[grant_vc] decrements at the edge.
    - Re-arbitrate in the same cycle with mask[grant_vc]=1 and using pre-decrement credits for the other VCs.
    - If there is a winner, load it and stay in GRANT: back-to-back grants, 1 per cycle. Otherwise go to IDLE with grant_valid=0.
  - GRANT, grant_ready=0:
    - grant_vc and grant_time are held stable, with no re-arbitration, even if an older VC arrives.
    - If req_valid[grant_vc] drops (requester withdrew): go to IDLE next edge, grant_valid=0, no credit consumed, no pop.
- Credits:
  - Return on VC i with credit[i]<VC_DEPTH: +1.
  - Return on VC i with credit[i]==VC_DEPTH: ignored and credit_err set (sticky until reset).
  - Handshake decrement and return on the same VC in the same cycle: net unchanged. This is never an error, even at VC_DEPTH.
  - Underflow is impossible because eligibility requires credit != 0.
- Requester contract: req_valid[i] may stay high the cycle after pop[i]. The mask makes that harmless for the handshake cycle only.

Test Plan:
- Oldest wins: req_valid=4'b1111, times (0..3)=40,10,30,20, full credits. Required: grant_valid=1 one cycle later, grant_vc=1, grant_time=10.
- Tie and hold:
  - Step 1: times all 5, grant_ready=0 for 3 cycles. Required: grant_vc=0, stable for 3 cycles.
  - Step 2: change time_in_2 to 1 during the hold. Required: grant still vc 0.
  - Step 3: ready=1. Required: pop=4'b0001, next grant vc 2.
- Back-to-back and credit drain:
  - Stimulus: only VC3 requesting, VC_DEPTH=4, grant_ready=1 constantly.
  - Required: pop[3] is high on alternate cycles, because the handshake cycle masks VC3 and the next IDLE cycle re-grants it.
  - After 4 pops, credit[3]=0 and grant_valid stays 0.
  - Then one credit return on vc 3: required grant_valid=1 two cycles later.
- Simultaneous credit events: credit[1]=4, handshake on vc1 plus credit_ret_vc=1 in the same cycle. Required: credit[1]=4, credit_err=0. Then a lone return on vc1: credit_err=1, stays 1.
- Withdrawal: grant on vc2 with ready=0, then req_valid[2]->0. Required: grant_valid=0 next cycle, no pop, credit[2] unchanged.
- Reset mid-grant: assert reset while in GRANT with credits partly consumed. Required: next cycle grant_valid=0, pop=0, all credits=4, credit_err=0.
